// File: rtl/dcache_line_adapter.sv
// dcache_line_adapter
//   Responder for the data cache's DFP line interface. Takes one 256-bit line
//   read or write request at a time and turns it into a BEATS-beat burst of
//   BEAT_W-bit beats on the memory port. It returns a one-cycle dfp_resp
//   pulse when the burst finishes.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   dfp_addr      line address from the cache (byte-in-line bits ignored)
//   dfp_read      line read request, level, held until dfp_resp
//   dfp_write     line write request, level, held until dfp_resp (wins over read)
//   dfp_wdata     writeback line data
//   dfp_rdata     returned line, valid with dfp_resp, held until the next read completes
//   dfp_resp      one-cycle completion pulse
//   bmem_addr     line-aligned burst address
//   bmem_read     burst read request, held until bmem_ready
//   bmem_write    write beat valid
//   bmem_wdata    write beat data
//   bmem_ready    memory accepts the read request / write beat this cycle
//   bmem_rdata    read beat data
//   bmem_rvalid   read beat valid
module dcache_line_adapter #(
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned BEATS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             dfp_addr,
  input  logic                    dfp_read,
  input  logic                    dfp_write,
  input  logic [BEAT_W*BEATS-1:0] dfp_wdata,
  output logic [BEAT_W*BEATS-1:0] dfp_rdata,
  output logic                    dfp_resp,
  output logic [31:0]             bmem_addr,
  output logic                    bmem_read,
  output logic                    bmem_write,
  output logic [BEAT_W-1:0]       bmem_wdata,
  input  logic                    bmem_ready,
  input  logic [BEAT_W-1:0]       bmem_rdata,
  input  logic                    bmem_rvalid
);

  localparam int unsigned LINE_W = BEAT_W * BEATS;
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_DATA,
    DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q;
  logic [31:0]                  addr_q;
  // Shared line buffer: holds the writeback line, or collects read beats.
  logic [BEATS-1:0][BEAT_W-1:0] line_q, line_d;
  logic [LINE_W-1:0]            rdata_q;

  // Byte-in-line address bits are dropped on capture.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dfp_addr[OFF_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dfp_write)     state_d = WR_DATA;
        else if (dfp_read) state_d = RD_REQ;
      end
      RD_REQ:  if (bmem_ready)                   state_d = RD_DATA;
      RD_DATA: if (bmem_rvalid && cnt_q == LAST) state_d = DONE;
      WR_DATA: if (bmem_ready && cnt_q == LAST)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line buffer with the incoming read beat merged into its slot.
  always_comb begin
    line_d        = line_q;
    line_d[cnt_q] = bmem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dfp_write || dfp_read) begin
            addr_q <= {dfp_addr[31:OFF_W], {OFF_W{1'b0}}};
            cnt_q  <= '0;
            if (dfp_write) line_q <= dfp_wdata;
          end
        end
        RD_DATA: begin
          if (bmem_rvalid) begin
            line_q <= line_d;
            cnt_q  <= cnt_q + 1'b1;
            // dfp_rdata only changes when a complete line has arrived.
            if (cnt_q == LAST) rdata_q <= line_d;
          end
        end
        WR_DATA: begin
          if (bmem_ready) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dfp_resp   = (state_q == DONE);
    dfp_rdata  = rdata_q;
    bmem_read  = (state_q == RD_REQ);
    bmem_write = (state_q == WR_DATA);
    bmem_addr  = addr_q;
    bmem_wdata = (state_q == WR_DATA) ? line_q[cnt_q] : '0;
  end

endmodule

// File: tb/tb_dcache_line_adapter.sv
// tb_dcache_line_adapter
//   Directed and randomized bench for dcache_line_adapter. A behavioural memory
//   responder inside the bench drives ready/rvalid. The expected beats,
//   addresses, response timing and returned lines come from the request
//   itself: a line sliced into beats, and a count of accepted beats.
module tb_dcache_line_adapter;

  localparam int unsigned BEAT_W = 64;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned LINE_W = BEAT_W * BEATS;
  localparam int          LIMIT  = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [31:0]       dfp_addr = '0;
  logic              dfp_read = 1'b0;
  logic              dfp_write = 1'b0;
  logic [LINE_W-1:0] dfp_wdata = '0;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;
  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready = 1'b0;
  logic [BEAT_W-1:0] bmem_rdata = '0;
  logic              bmem_rvalid = 1'b0;

  int                n_checks = 0;
  int                n_fail = 0;
  logic [LINE_W-1:0] exp_rdata = '0;

  dcache_line_adapter #(.BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
    .clk        (clk),
    .rst        (rst),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_all_zero();
    chk("rst_resp", dfp_resp, 1'b0);
    chk("rst_rdata", dfp_rdata, {LINE_W{1'b0}});
    chk("rst_read", bmem_read, 1'b0);
    chk("rst_write", bmem_write, 1'b0);
    chk("rst_addr", bmem_addr, 32'h0);
    chk("rst_wdata", bmem_wdata, {BEAT_W{1'b0}});
  endtask

  // One cycle with no request pending; memory inputs carry noise.
  task automatic idle_step();
    @(posedge clk); #1;
    bmem_ready  = 1'($urandom_range(0, 1));
    bmem_rvalid = 1'($urandom_range(0, 1));
    bmem_rdata  = {$urandom, $urandom};
    chk("idle_resp", dfp_resp, 1'b0);
    chk("idle_read", bmem_read, 1'b0);
    chk("idle_write", bmem_write, 1'b0);
    chk("idle_rdata", dfp_rdata, exp_rdata);
  endtask

  // first: observation index of the first burst cycle (1 when called in an
  // IDLE cycle, 2 when called in the DONE cycle). exp_c < 0 skips the latency check.
  task automatic do_write(input logic [31:0] a, input logic [LINE_W-1:0] d, input int first,
                          input int stall_beat, input int stall_len, input bit rnd,
                          input bit also_read, input int exp_c);
    logic [31:0] al;
    int k;
    int stalls;
    bit done;
    al = {a[31:5], 5'b0};
    k = 0; stalls = 0; done = 0;
    dfp_addr = a; dfp_wdata = d; dfp_write = 1'b1; dfp_read = also_read;
    for (int c = 1; c <= LIMIT && !done; c++) begin
      @(posedge clk); #1;
      if (c >= first) begin
        dfp_addr = $urandom;
        dfp_wdata[31:0] = $urandom;
      end
      bmem_rvalid = 1'($urandom_range(0, 1));
      bmem_rdata  = {$urandom, $urandom};
      chk("wr_rdata_hold", dfp_rdata, exp_rdata);
      chk("wr_no_read", bmem_read, 1'b0);
      if (c < first) begin
        chk("wr_pre_write", bmem_write, 1'b0);
        chk("wr_pre_resp", dfp_resp, 1'b0);
        bmem_ready = 1'($urandom_range(0, 1));
      end else if (k < BEATS) begin
        chk("wr_valid", bmem_write, 1'b1);
        chk("wr_addr", bmem_addr, al);
        chk("wr_beat", bmem_wdata, d[k*BEAT_W +: BEAT_W]);
        chk("wr_resp_early", dfp_resp, 1'b0);
        if (rnd) bmem_ready = 1'($urandom_range(0, 1));
        else if (k == stall_beat && stalls < stall_len) begin
          bmem_ready = 1'b0;
          stalls++;
        end else bmem_ready = 1'b1;
        if (bmem_ready) k++;
      end else begin
        chk("wr_resp", dfp_resp, 1'b1);
        chk("wr_end_write", bmem_write, 1'b0);
        if (exp_c >= 0) chk("wr_latency", c, exp_c);
        dfp_write = 1'b0; dfp_read = 1'b0; bmem_ready = 1'b0;
        done = 1;
      end
    end
    if (!done) chk("wr_timeout", done, 1'b1);
  endtask

  // abort_k >= 0 pulses rst once that many beats have been delivered.
  task automatic do_read(input logic [31:0] a, input logic [LINE_W-1:0] line, input int first,
                         input bit rnd, input int abort_k, input int exp_c);
    logic [31:0] al;
    int k;
    int req_cycles;
    bit accepted;
    bit done;
    al = {a[31:5], 5'b0};
    k = 0; req_cycles = 0; accepted = 0; done = 0;
    dfp_addr = a; dfp_read = 1'b1; dfp_write = 1'b0;
    for (int c = 1; c <= LIMIT && !done; c++) begin
      @(posedge clk); #1;
      if (c >= first) dfp_addr = $urandom;
      bmem_rvalid = 1'b0;
      bmem_rdata  = {$urandom, $urandom};
      chk("rd_no_write", bmem_write, 1'b0);
      if (c < first) begin
        chk("rd_pre_read", bmem_read, 1'b0);
        chk("rd_pre_resp", dfp_resp, 1'b0);
        chk("rd_pre_rdata", dfp_rdata, exp_rdata);
        bmem_ready = 1'($urandom_range(0, 1));
      end else if (!accepted) begin
        chk("rd_req", bmem_read, 1'b1);
        chk("rd_addr", bmem_addr, al);
        chk("rd_req_resp", dfp_resp, 1'b0);
        chk("rd_req_rdata", dfp_rdata, exp_rdata);
        req_cycles++;
        bmem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bmem_ready) accepted = 1;
        else bmem_rvalid = 1'($urandom_range(0, 1));
      end else if (k < BEATS && k == abort_k) begin
        #2 rst = 1'b1;
        #1 check_all_zero();
        dfp_read = 1'b0; bmem_rvalid = 1'b0; bmem_ready = 1'b0;
        exp_rdata = '0;
        @(negedge clk); rst = 1'b0;
        done = 1;
      end else if (k < BEATS) begin
        chk("rd_req_drop", bmem_read, 1'b0);
        chk("rd_data_resp", dfp_resp, 1'b0);
        chk("rd_data_rdata", dfp_rdata, exp_rdata);
        bmem_ready  = 1'($urandom_range(0, 1));
        bmem_rvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bmem_rvalid) begin
          bmem_rdata = line[k*BEAT_W +: BEAT_W];
          k++;
        end
      end else begin
        chk("rd_resp", dfp_resp, 1'b1);
        chk("rd_line", dfp_rdata, line);
        chk("rd_end_read", bmem_read, 1'b0);
        if (!rnd) chk("rd_req_cycles", req_cycles, 1);
        if (exp_c >= 0) chk("rd_latency", c, exp_c);
        exp_rdata = line;
        dfp_read = 1'b0; bmem_ready = 1'b0;
        done = 1;
      end
    end
    if (!done) chk("rd_timeout", done, 1'b1);
  endtask

  initial begin
    logic [LINE_W-1:0] l;
    logic [31:0]       a;
    int                kind;
    int                first;

    // Reset value, asserted asynchronously between edges.
    #2 rst = 1'b1;
    #1 check_all_zero();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    idle_step();

    // Zero-wait write: beats A..D on cycles 1-4, resp on cycle 5.
    l = {64'hD, 64'hC, 64'hB, 64'hA};
    do_write(32'h0000_1234, l, 1, -1, 0, 0, 0, 5);
    idle_step();

    // Zero-wait read: one request cycle, four beats, resp the cycle after.
    l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read(32'h8000_0040, l, 1, 0, -1, 6);
    idle_step();

    // Beat 2 stalled three cycles: resp moves to cycle 8.
    do_write(32'h0000_2000, rand_line(), 1, 2, 3, 0, 0, 8);
    idle_step();

    // Writeback then refill with the new request raised in the DONE cycle.
    do_write(32'h1234_5678, rand_line(), 1, -1, 0, 0, 0, 5);
    do_read(32'h0BAD_F00D, rand_line(), 2, 0, -1, 7);
    idle_step();

    // Read and write both raised: write wins, no bmem_read ever.
    do_write(32'h0000_3300, rand_line(), 1, -1, 0, 0, 1, 5);
    idle_step();

    // Reset after two read beats, then a fresh read.
    do_read(32'h0000_4000, rand_line(), 1, 0, 2, -1);
    idle_step();
    do_read(32'h0000_5000, rand_line(), 1, 0, -1, 6);

    // Random mix with random memory stalls, gaps and back-to-back requests.
    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 2);
      first = 2;
      if ($urandom_range(0, 1) == 1) begin
        idle_step();
        first = 1;
      end
      a = $urandom;
      l = rand_line();
      if (kind == 1) do_read(a, l, first, 1, -1, -1);
      else           do_write(a, l, first, -1, 0, 1, kind == 2, -1);
    end
    idle_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
